// File: rtl/onset_enumerator.sv
// Walks lo..hi, evaluates the 16-input projection F on each vector and streams out matches over valid/ready.
// Optional ONSET_ENUM_ABORT_EN adds an abort input and an aborted pulse.
module onset_enumerator #(
    parameter bit          TARGET = 1'b1,
    parameter int unsigned CNT_W  = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      lo,
    input  logic [15:0]      hi,
    output logic             busy,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [15:0]      vec_data,
    output logic             done,
    output logic [CNT_W-1:0] match_count
`ifdef ONSET_ENUM_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam int unsigned VEC_W = 16;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

    state_t             state_q;
    logic [VEC_W-1:0]   cur_q;
    logic [VEC_W-1:0]   hi_q;
    logic [VEC_W-1:0]   vec_data_q;
    logic               vec_valid_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   match_count_q;
`ifdef ONSET_ENUM_ABORT_EN
    logic               abort_pend_q;
    logic               aborted_q;
`endif

    logic hit_c;
    logic xfer_c;
    logic free_c;
    logic abort_c;

    // Projection function: F = x0 | (~x6 & (x7 | P))
    function automatic logic f_eval(input logic [VEC_W-1:0] x);
        logic p;
        p = ~x[11] & ~x[12] & ~(x[13] & x[14])
          & ~((x[8] == x[9]) & (x[9] == x[10]))
          & ~(x[8] & x[15])
          & ((~x[13] & ~x[14]) ^ (~x[8] & ~x[15]));
        return x[0] | (~x[6] & (x[7] | p));
    endfunction

    assign hit_c  = (f_eval(cur_q) == TARGET);
    assign xfer_c = vec_valid_q & vec_ready;
    assign free_c = ~vec_valid_q | vec_ready;
`ifdef ONSET_ENUM_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cur_q         <= '0;
            hi_q          <= '0;
            vec_data_q    <= '0;
            vec_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            match_count_q <= '0;
`ifdef ONSET_ENUM_ABORT_EN
            abort_pend_q  <= 1'b0;
            aborted_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef ONSET_ENUM_ABORT_EN
            aborted_q <= 1'b0;
`endif
            // Saturating transfer count
            if (xfer_c && (match_count_q != '1)) begin
                match_count_q <= match_count_q + CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        match_count_q <= '0;
                        if (lo <= hi) begin
                            cur_q   <= lo;
                            hi_q    <= hi;
                            busy_q  <= 1'b1;
                            state_q <= SCAN;
                        end else begin
                            state_q <= FIN;
                        end
                    end
                end
                SCAN: begin
                    if (abort_c) begin
                        vec_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= FIN;
`ifdef ONSET_ENUM_ABORT_EN
                        abort_pend_q <= 1'b1;
`endif
                    end else if (free_c) begin
                        if (hit_c) begin
                            vec_data_q  <= cur_q;
                            vec_valid_q <= 1'b1;
                        end else begin
                            vec_valid_q <= 1'b0;
                        end
                        // Stop on the latched bound so hi=0xFFFF never wraps cur
                        if (cur_q == hi_q) begin
                            state_q <= DRAIN;
                        end else begin
                            cur_q <= cur_q + VEC_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (abort_c) begin
                        vec_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= FIN;
`ifdef ONSET_ENUM_ABORT_EN
                        abort_pend_q <= 1'b1;
`endif
                    end else if (free_c) begin
                        vec_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= FIN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
`ifdef ONSET_ENUM_ABORT_EN
                    aborted_q    <= abort_pend_q;
                    abort_pend_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign vec_valid   = vec_valid_q;
    assign vec_data    = vec_data_q;
    assign done        = done_q;
    assign match_count = match_count_q;
`ifdef ONSET_ENUM_ABORT_EN
    assign aborted     = aborted_q;
`endif

endmodule

// File: tb/tb_onset_enumerator.sv
// Randomized self-checking bench for onset_enumerator; two instances cover TARGET=1 and TARGET=0.
module tb_onset_enumerator;

    localparam int unsigned CNT_W = 17;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             vec_ready;
    logic [15:0]      lo;
    logic [15:0]      hi;
    logic             busy1, busy0, vv1, vv0, done1, done0;
    logic [15:0]      vd1, vd0;
    logic [CNT_W-1:0] mc1, mc0;
`ifdef ONSET_ENUM_ABORT_EN
    logic             abort;
    logic             ab1, ab0;
`endif

    always #5 clk = ~clk;

    onset_enumerator #(.TARGET(1'b1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
        .busy(busy1), .vec_valid(vv1), .vec_ready(vec_ready), .vec_data(vd1),
        .done(done1), .match_count(mc1)
`ifdef ONSET_ENUM_ABORT_EN
        , .abort(abort), .aborted(ab1)
`endif
    );

    onset_enumerator #(.TARGET(1'b0), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
        .busy(busy0), .vec_valid(vv0), .vec_ready(vec_ready), .vec_data(vd0),
        .done(done0), .match_count(mc0)
`ifdef ONSET_ENUM_ABORT_EN
        , .abort(abort), .aborted(ab0)
`endif
    );

    logic             sel;
    logic             busy_s, vv_s, done_s;
    logic [15:0]      vd_s;
    logic [CNT_W-1:0] mc_s;
    assign busy_s = sel ? busy1 : busy0;
    assign vv_s   = sel ? vv1   : vv0;
    assign done_s = sel ? done1 : done0;
    assign vd_s   = sel ? vd1   : vd0;
    assign mc_s   = sel ? mc1   : mc0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference F from the boolean definition, using bit counts
    function automatic bit f_ref(input int x);
        int b[16];
        int ones;
        bit p;
        for (int i = 0; i < 16; i++) b[i] = (x >> i) & 1;
        ones = b[8] + b[9] + b[10];
        p = (b[11] == 0) && (b[12] == 0) && (b[13] + b[14] < 2)
            && (ones == 1 || ones == 2) && (b[8] + b[15] < 2)
            && (((b[13] + b[14]) == 0) != ((b[8] + b[15]) == 0));
        return (b[0] == 1) || ((b[6] == 0) && ((b[7] == 1) || p));
    endfunction

    task automatic settle();
        vec_ready = 1'b1;
        start     = 1'b0;
        for (int k = 0; k < 200 && (busy1 || busy0); k++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    // mode 0: ready held 1, 1: random ready, 2: ready low for 5 cycles from first valid
    task automatic run(input int l, input int h, input bit tg, input int mode, input bit restart);
        int   q[$];
        int   exp_total;
        int   xfers = 0;
        int   cyc = 0;
        int   lat;
        int   stall_left = 5;
        bit   prev_stall = 1'b0;
        bit   seen_valid = 1'b0;
        bit   got_done = 1'b0;
        logic [15:0] prev_data = '0;
        sel = tg;
        if (l <= h) for (int v = l; v <= h; v++) if (f_ref(v) == tg) q.push_back(v);
        exp_total = q.size();
        lat = (l <= h) ? (h - l + 1) + 3 : 2;
        @(posedge clk); #1;
        start = 1'b1; lo = 16'(l); hi = 16'(h);
        vec_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3000 && !got_done; k++) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(vv_s), 32'd1);
                chk("hold_data", 32'(vd_s), 32'(prev_data));
            end
            if (vv_s && vec_ready) begin
                if (q.size() == 0) chk("extra_xfer", 32'(vv_s), 32'd0);
                else chk("data", 32'(vd_s), 32'(q.pop_front()));
                xfers++;
            end
            if (exp_total == 0) chk("no_valid", 32'(vv_s), 32'd0);
            if (cyc == 1 && l <= h) chk("busy", 32'(busy_s), 32'd1);
            if (vv_s) seen_valid = 1'b1;
            prev_stall = vv_s && !vec_ready;
            prev_data  = vd_s;
            if (done_s) begin
                got_done = 1'b1;
                chk("count_xfers", 32'(mc_s), 32'(xfers));
                chk("count_model", 32'(mc_s), 32'(exp_total));
                chk("all_emitted", 32'(q.size()), 32'd0);
                chk("busy_at_done", 32'(busy_s), 32'd0);
                if (mode == 0) chk("latency", 32'(cyc), 32'(lat));
            end else begin
                @(posedge clk); #1;
                start = restart && (cyc == 2);
                if (start) begin lo = 16'h0000; hi = 16'hFFFF; end
                case (mode)
                    0: vec_ready = 1'b1;
                    1: vec_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (seen_valid && stall_left > 0) stall_left--;
                        vec_ready = (stall_left == 0);
                    end
                endcase
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", 32'(got_done), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(done_s), 32'd0);
        chk("count_hold", 32'(mc_s), 32'(xfers));
        settle();
    endtask

    initial begin
        int l, h, done_hits, xf;
        bit ok;
        rst = 1'b1; start = 1'b0; vec_ready = 1'b0; lo = '0; hi = '0; sel = 1'b1;
`ifdef ONSET_ENUM_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_valid", 32'(vv1), 32'd0);
        chk("rst_data", 32'(vd1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_count", 32'(mc1), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        run(16'h0000, 16'h0003, 1'b1, 0, 1'b0);
        run(16'h0100, 16'h0103, 1'b1, 0, 1'b1);
        run(16'h0100, 16'h0103, 1'b1, 2, 1'b0);
        run(16'h0080, 16'h0080, 1'b1, 0, 1'b0);
        run(16'h00C0, 16'h00C0, 1'b1, 0, 1'b0);
        run(16'h0140, 16'h0140, 1'b1, 0, 1'b0);
        run(16'hFFF0, 16'hFFFF, 1'b1, 0, 1'b0);
        run(16'hFFF0, 16'hFFFF, 1'b0, 0, 1'b0);
        run(16'h0005, 16'h0002, 1'b1, 0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            l = int'($urandom_range(0, 65535));
            h = l + int'($urandom_range(0, 24));
            if (h > 65535) h = 65535;
            if (r == 5) h = l - 1;
            run(l, h, 1'($urandom_range(0, 1)), 1, 1'b0);
        end

        // Asynchronous reset with a pending vector
        sel = 1'b1;
        @(posedge clk); #1; lo = 16'h0100; hi = 16'h0103; start = 1'b1; vec_ready = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin @(negedge clk); ok = vv1; end
        chk("rst_pre_valid_seen", 32'(ok), 32'd1);
        @(posedge clk); #1; vec_ready = 1'b1;
        @(posedge clk); #1; vec_ready = 1'b0;
        @(negedge clk);
        chk("rst_pre_count", 32'(mc1), 32'd1);
        chk("rst_pre_valid", 32'(vv1), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(vv1), 32'd0);
        chk("rst_mid_busy", 32'(busy1), 32'd0);
        chk("rst_mid_count", 32'(mc1), 32'd0);
        @(negedge clk); rst = 1'b0;
        done_hits = 0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); if (done1 || done0) done_hits++; end
        chk("rst_no_done", 32'(done_hits), 32'd0);
        settle();

`ifdef ONSET_ENUM_ABORT_EN
        sel = 1'b1; xf = 0; ok = 1'b0;
        @(posedge clk); #1; lo = 16'h0100; hi = 16'h0103; start = 1'b1; vec_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 20 && xf < 2; k++) begin
            @(negedge clk);
            if (vv1 && vec_ready) xf++;
        end
        @(posedge clk); #1; abort = 1'b1; vec_ready = 1'b0;
        @(posedge clk); #1; abort = 1'b0; vec_ready = 1'b1;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (vv1) chk("abort_no_valid", 32'(vv1), 32'd0);
            if (done1) begin
                ok = 1'b1;
                chk("abort_flag", 32'(ab1), 32'd1);
                chk("abort_count", 32'(mc1), 32'd2);
            end
        end
        chk("abort_done_seen", 32'(ok), 32'd1);
        @(negedge clk);
        chk("abort_pulse", 32'(ab1), 32'd0);
        settle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/onset_enumerator.md
Name: onset_enumerator

Overview:
- Inverse-direction companion to the team's 16-input single-output spla projection function F.
- F evaluates one input vector to one bit; this block walks a programmed range of input vectors, evaluates F on each, and streams out every vector for which F equals TARGET.
- Streaming uses a valid/ready interface.
- Used for ON-set/OFF-set extraction and for cross-checking D-reduced projections against their originals.

Parameters:
- TARGET, 1, output polarity to extract: 1 selects the ON-set, 0 selects the OFF-set.
- CNT_W, 17, width of match_count; must be at least 17 to hold 65536.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- lo  input  16  first vector of the range; bit i is xi; sampled on start.
- hi  input  16  last vector of the range, inclusive; sampled on start.
- busy  output  1  high in SCAN and DRAIN.
- vec_valid  output  1  vec_data holds a matching vector.
- vec_ready  input  1  consumer accepts the vector when vec_valid and vec_ready are both high.
- vec_data  output  16  matching vector.
- done  output  1  one-cycle pulse at the end of a run.
- match_count  output  CNT_W  number of accepted transfers in the current or most recent run.

Behaviour:
- Function evaluated on vector x[15:0]:
  - P = ~x11 & ~x12 & ~(x13&x14) & ~(x8==x9==x10) & ~(x8&x15) & ((~x13&~x14) ^ (~x8&~x15)).
  - F = x0 | (~x6 & (x7 | P)).
  - x1..x5 do not affect F.
  - hit = (F == TARGET).
- Reset values: state=IDLE, busy=0, vec_valid=0, vec_data=0, done=0, match_count=0. The internal cursor cur and the latched hi also reset to 0.
- FSM states: IDLE, SCAN, DRAIN, FIN.
- IDLE:
  - On start with lo<=hi: latch lo into cur and hi into hi_r, clear match_count, go to SCAN.
  - On start with lo>hi: go to FIN directly. No vec_valid is raised and match_count=0.
- SCAN, one candidate per cycle:
  - The output register is free when vec_valid=0, or when vec_valid & vec_ready in this cycle.
  - If the register is free: evaluate hit(cur). On a hit, load vec_data<=cur and set vec_valid<=1; on no hit, vec_valid<=0 if the current entry was consumed.
  - Then, if cur==hi_r, go to DRAIN; otherwise cur<=cur+1.
  - If the register is not free, cur holds and nothing is evaluated.
- Wrap-around: cur is never incremented past hi_r. A run with hi=0xFFFF terminates without the counter wrapping. The comparison uses the latched hi_r, never the live hi port.
- DRAIN: wait until vec_valid=0, either because nothing is pending or the last transfer was accepted, then go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- match_count:
  - Increments by 1 on every transfer (vec_valid & vec_ready), saturating at all-ones.
  - Holds its value after done until the next accepted start.
- Data stability: while vec_valid=1 and vec_ready=0, vec_data and vec_valid are stable.
- Latency:
  - start in cycle t puts the block in SCAN at t+1.
  - The first candidate is evaluated at t+1; its vector is visible on vec_valid/vec_data at t+2.
  - With vec_ready held at 1, an N-vector range produces done at t+N+3.
- start while busy is ignored.
- Asynchronous rst mid-run returns all state to reset values immediately. Any pending vec_valid is dropped and done is not pulsed.

Optional Feature:
- Macro: ONSET_ENUM_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in SCAN or DRAIN drops any pending vec_valid in the next cycle without a transfer, then goes to FIN.
  - FIN pulses done as normal and also pulses an added output aborted (1 bit) in the same cycle.
  - match_count keeps the transfers accepted before the abort; a transfer in the abort cycle itself still counts.
  - abort is ignored in IDLE and FIN.
- Undefined: neither port exists and runs always go to completion.

Test Plan:
- TARGET=1, lo=0x0000, hi=0x0003, vec_ready=1 -> vectors 0x0001 then 0x0003 are emitted; done pulses; match_count=2.
- TARGET=1, lo=0x0100, hi=0x0103 (P=1 path) -> all 4 vectors emitted in order. Repeat with vec_ready=0 for 5 cycles after the first valid: vec_data holds 0x0100 and cur stalls; count=4 at the end.
- Single vectors with TARGET=1: lo=hi=0x0080 -> one output 0x0080. lo=hi=0x00C0 -> none, done, count=0. lo=hi=0x0140 -> none.
- lo=0xFFF0, hi=0xFFFF -> exactly the 8 odd vectors 0xFFF1..0xFFFF are emitted; the block returns to IDLE with no wrap and no extra outputs. With TARGET=0 the same range -> the 8 even vectors are emitted.
- lo=0x0005, hi=0x0002 start -> done one cycle after FIN entry, vec_valid never high, count=0. start pulsed again while busy on a valid run -> ignored.
- rst asserted mid-SCAN with vec_valid=1 -> vec_valid, busy, and match_count are 0 immediately and no done pulse occurs. With ONSET_ENUM_ABORT_EN: abort after the 2nd transfer of lo=0x0100, hi=0x0103 -> done and aborted pulse together, count=2.
